// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the Icache and Dcache refill/write ports.
// Default is fixed Dcache priority with anti-starvation; define ARB_RR_EN for round-robin.
module mem_port_arbiter #(
    parameter int offset_width = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           icache_mem_req,
    input  logic                           icache_mem_SUC,
    input  logic [31:0]                    addr_icache_mem,
    output logic                           mem_icache_addrOK,
    output logic                           mem_icache_dataOK,
    input  logic                           dcache_mem_req,
    input  logic                           dcache_mem_wr,
    input  logic                           dcache_mem_SUC,
    input  logic [1:0]                     dcache_mem_size,
    input  logic [3:0]                     dcache_mem_wstrb,
    input  logic [31:0]                    addr_dcache_mem,
    input  logic [31:0]                    dout_dcache_mem,
    output logic                           mem_dcache_addrOK,
    output logic                           mem_dcache_dataOK,
    output logic [(32<<offset_width)-1:0]  din_mem_cache,
    output logic                           arb_mem_req,
    output logic                           arb_mem_wr,
    output logic                           arb_mem_SUC,
    output logic [1:0]                     arb_mem_size,
    output logic [3:0]                     arb_mem_wstrb,
    output logic [31:0]                    arb_mem_addr,
    output logic [31:0]                    arb_mem_wdata,
    input  logic                           mem_arb_addrOK,
    input  logic                           mem_arb_dataOK,
    input  logic [(32<<offset_width)-1:0]  arb_rdata,
    output logic [1:0]                     arb_grant
);

    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

    state_t state;
    logic   pick_d;
    logic   own_i;
    logic   own_d;

    assign own_i = arb_grant[0];
    assign own_d = arb_grant[1];

`ifdef ARB_RR_EN
    logic last_d;

    // On a tie the side that was not served last wins.
    assign pick_d = dcache_mem_req && (!icache_mem_req || !last_d);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_d <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_d) begin
                last_d <= 1'b1;
            end else if (icache_mem_req) begin
                last_d <= 1'b0;
            end
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign pick_d = dcache_mem_req && !(icache_mem_req && starve_cnt == LIMIT);

    // Counts Dcache grants that overtook a waiting Icache; any Icache grant or idle Icache clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_d && icache_mem_req) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            arb_mem_req <= 1'b0;
            arb_grant   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state       <= D_ADDR;
                        arb_mem_req <= 1'b1;
                        arb_grant   <= 2'b10;
                    end else if (icache_mem_req) begin
                        state       <= I_ADDR;
                        arb_mem_req <= 1'b1;
                        arb_grant   <= 2'b01;
                    end
                end
                I_ADDR: begin
                    if (mem_arb_addrOK && mem_arb_dataOK) begin
                        state       <= IDLE;
                        arb_mem_req <= 1'b0;
                        arb_grant   <= 2'b00;
                    end else if (mem_arb_addrOK) begin
                        state       <= I_DATA;
                        arb_mem_req <= 1'b0;
                    end else if (!icache_mem_req) begin
                        state       <= IDLE;
                        arb_mem_req <= 1'b0;
                        arb_grant   <= 2'b00;
                    end
                end
                I_DATA: begin
                    if (mem_arb_dataOK) begin
                        state     <= IDLE;
                        arb_grant <= 2'b00;
                    end
                end
                D_ADDR: begin
                    if (mem_arb_addrOK && mem_arb_dataOK) begin
                        state       <= IDLE;
                        arb_mem_req <= 1'b0;
                        arb_grant   <= 2'b00;
                    end else if (mem_arb_addrOK) begin
                        state       <= D_DATA;
                        arb_mem_req <= 1'b0;
                    end else if (!dcache_mem_req) begin
                        state       <= IDLE;
                        arb_mem_req <= 1'b0;
                        arb_grant   <= 2'b00;
                    end
                end
                D_DATA: begin
                    if (mem_arb_dataOK) begin
                        state     <= IDLE;
                        arb_grant <= 2'b00;
                    end
                end
                default: begin
                    state       <= IDLE;
                    arb_mem_req <= 1'b0;
                    arb_grant   <= 2'b00;
                end
            endcase
        end
    end

    // Request fields follow the current owner for the whole transaction and read as zero when idle.
    always_comb begin
        arb_mem_wr    = 1'b0;
        arb_mem_SUC   = 1'b0;
        arb_mem_size  = 2'd0;
        arb_mem_wstrb = 4'd0;
        arb_mem_addr  = 32'd0;
        arb_mem_wdata = 32'd0;
        if (own_d) begin
            arb_mem_wr    = dcache_mem_wr;
            arb_mem_SUC   = dcache_mem_SUC;
            arb_mem_size  = dcache_mem_size;
            arb_mem_wstrb = dcache_mem_wstrb;
            arb_mem_addr  = addr_dcache_mem;
            arb_mem_wdata = dout_dcache_mem;
        end else if (own_i) begin
            arb_mem_SUC   = icache_mem_SUC;
            arb_mem_size  = 2'd2;
            arb_mem_addr  = addr_icache_mem;
        end
    end

    assign mem_icache_addrOK = (state == I_ADDR) && mem_arb_addrOK;
    assign mem_dcache_addrOK = (state == D_ADDR) && mem_arb_addrOK;
    assign mem_icache_dataOK = mem_arb_dataOK &&
                               ((state == I_DATA) || ((state == I_ADDR) && mem_arb_addrOK));
    assign mem_dcache_dataOK = mem_arb_dataOK &&
                               ((state == D_DATA) || ((state == D_ADDR) && mem_arb_addrOK));

    assign din_mem_cache = arb_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: agents push expected grants/requests, a monitor checks DUT handshakes.
// Define ARB_RR_EN for both RTL and bench to exercise the round-robin build.
module tb_mem_port_arbiter;

    localparam int OW    = 2;
    localparam int LW    = 32 << OW;
    localparam int MAXW  = 300;
    localparam logic [LW-1:0] RDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic          clk;
    logic          rstn;
    logic          icache_mem_req;
    logic          icache_mem_SUC;
    logic [31:0]   addr_icache_mem;
    logic          mem_icache_addrOK;
    logic          mem_icache_dataOK;
    logic          dcache_mem_req;
    logic          dcache_mem_wr;
    logic          dcache_mem_SUC;
    logic [1:0]    dcache_mem_size;
    logic [3:0]    dcache_mem_wstrb;
    logic [31:0]   addr_dcache_mem;
    logic [31:0]   dout_dcache_mem;
    logic          mem_dcache_addrOK;
    logic          mem_dcache_dataOK;
    logic [LW-1:0] din_mem_cache;
    logic          arb_mem_req;
    logic          arb_mem_wr;
    logic          arb_mem_SUC;
    logic [1:0]    arb_mem_size;
    logic [3:0]    arb_mem_wstrb;
    logic [31:0]   arb_mem_addr;
    logic [31:0]   arb_mem_wdata;
    logic          mem_arb_addrOK;
    logic          mem_arb_dataOK;
    logic [LW-1:0] arb_rdata;
    logic [1:0]    arb_grant;

    mem_port_arbiter #(.offset_width(OW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rstn(rstn),
        .icache_mem_req(icache_mem_req), .icache_mem_SUC(icache_mem_SUC),
        .addr_icache_mem(addr_icache_mem),
        .mem_icache_addrOK(mem_icache_addrOK), .mem_icache_dataOK(mem_icache_dataOK),
        .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
        .dcache_mem_SUC(dcache_mem_SUC), .dcache_mem_size(dcache_mem_size),
        .dcache_mem_wstrb(dcache_mem_wstrb), .addr_dcache_mem(addr_dcache_mem),
        .dout_dcache_mem(dout_dcache_mem),
        .mem_dcache_addrOK(mem_dcache_addrOK), .mem_dcache_dataOK(mem_dcache_dataOK),
        .din_mem_cache(din_mem_cache),
        .arb_mem_req(arb_mem_req), .arb_mem_wr(arb_mem_wr), .arb_mem_SUC(arb_mem_SUC),
        .arb_mem_size(arb_mem_size), .arb_mem_wstrb(arb_mem_wstrb),
        .arb_mem_addr(arb_mem_addr), .arb_mem_wdata(arb_mem_wdata),
        .mem_arb_addrOK(mem_arb_addrOK), .mem_arb_dataOK(mem_arb_dataOK),
        .arb_rdata(arb_rdata), .arb_grant(arb_grant)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        suc;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [1:0] side;
        bit         gap;
    } grant_t;

    req_t       exp_i_q[$];
    req_t       exp_d_q[$];
    grant_t     grant_q[$];
    logic [1:0] data_q[$];

    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         last_done = -100;
    int         addr_lat = 1;
    int         data_lat = 1;
    bit         stray_pulse = 0;
    bit         idle_next = 0;
    logic       prev_req = 1'b0;
    logic [1:0] cur_owner = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not expected or never arrived", name);
    endtask

    // Downstream memory model: addrOK addr_lat cycles into the request, dataOK data_lat cycles later.
    initial begin
        int cnt;
        int phase;
        cnt = 0;
        phase = 0;
        mem_arb_addrOK = 1'b0;
        mem_arb_dataOK = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_arb_addrOK = 1'b0;
            mem_arb_dataOK = 1'b0;
            if (!rstn) begin
                phase = 0;
            end else begin
                if (phase == 0 && arb_mem_req) begin
                    cnt = 0;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (!arb_mem_req) begin
                        phase = 0;
                    end else if (cnt == addr_lat) begin
                        mem_arb_addrOK = 1'b1;
                        if (data_lat == 0) begin
                            mem_arb_dataOK = 1'b1;
                            phase = 0;
                        end else begin
                            cnt = 0;
                            phase = 2;
                        end
                    end else begin
                        cnt++;
                    end
                end else if (phase == 2) begin
                    cnt++;
                    if (cnt == data_lat) begin
                        mem_arb_dataOK = 1'b1;
                        phase = 0;
                    end
                end else if (stray_pulse) begin
                    mem_arb_dataOK = 1'b1;
                    stray_pulse = 0;
                end
            end
        end
    end

    // Monitor: grants, forwarded addrOK and dataOK are compared against the expected queues.
    always @(negedge clk) begin
        grant_t g;
        req_t   r;
        if (!rstn) begin
            prev_req = 1'b0;
            idle_next = 0;
        end else begin
            if (idle_next) begin
                check_output("idle_bubble", {arb_mem_req, arb_grant}, 3'b000);
                idle_next = 0;
            end
            if (arb_mem_req && !prev_req) begin
                if (grant_q.size() == 0) begin
                    report_fail("unexpected_grant");
                end else begin
                    g = grant_q.pop_front();
                    check_output("grant_owner", arb_grant, g.side);
                    if (g.gap) check_output("grant_gap", cycle - last_done, 2);
                    cur_owner = g.side;
                end
            end
            prev_req = arb_mem_req;
            if (mem_icache_addrOK || mem_dcache_addrOK) begin
                check_output("addrOK_owner", {mem_dcache_addrOK, mem_icache_addrOK}, cur_owner);
                if (cur_owner == 2'b10 && exp_d_q.size() > 0) begin
                    r = exp_d_q.pop_front();
                    check_output("d_wdata", arb_mem_wdata, r.wdata);
                end else if (cur_owner == 2'b01 && exp_i_q.size() > 0) begin
                    r = exp_i_q.pop_front();
                end else begin
                    report_fail("unexpected_addrOK");
                    r = '{32'd0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0};
                end
                check_output("req_addr", arb_mem_addr, r.addr);
                check_output("req_fields", {arb_mem_req, arb_mem_wr, arb_mem_SUC, arb_mem_size, arb_mem_wstrb},
                             {1'b1, r.wr, r.suc, r.size, r.wstrb});
                data_q.push_back(cur_owner);
            end
            if (mem_icache_dataOK || mem_dcache_dataOK) begin
                if (data_q.size() == 0) begin
                    report_fail("unexpected_dataOK");
                end else begin
                    check_output("dataOK_owner", {mem_dcache_dataOK, mem_icache_dataOK}, data_q.pop_front());
                    check_output("rdata_bcast", din_mem_cache, RDATA);
                end
                last_done = cycle;
                idle_next = 1;
            end
        end
    end

    task automatic icache_req(input int n, input logic [31:0] base, input logic suc);
        int w;
        @(posedge clk);
        #1;
        icache_mem_req = 1'b1;
        icache_mem_SUC = suc;
        for (int i = 0; i < n; i++) begin
            addr_icache_mem = base + 32'(4 * i);
            exp_i_q.push_back('{addr_icache_mem, 1'b0, suc, 2'd2, 4'd0, 32'd0});
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!mem_icache_addrOK && w < MAXW);
            if (!mem_icache_addrOK) report_fail("icache_addrOK_timeout");
            @(posedge clk);
            #1;
        end
        icache_mem_req = 1'b0;
    endtask

    task automatic dcache_req(input int n, input logic [31:0] base, input logic wr, input logic suc,
                              input logic [1:0] size, input logic [3:0] wstrb, input logic [31:0] wdata);
        int w;
        @(posedge clk);
        #1;
        dcache_mem_req   = 1'b1;
        dcache_mem_wr    = wr;
        dcache_mem_SUC   = suc;
        dcache_mem_size  = size;
        dcache_mem_wstrb = wstrb;
        dout_dcache_mem  = wdata;
        for (int i = 0; i < n; i++) begin
            addr_dcache_mem = base + 32'(4 * i);
            exp_d_q.push_back('{addr_dcache_mem, wr, suc, size, wstrb, wdata});
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!mem_dcache_addrOK && w < MAXW);
            if (!mem_dcache_addrOK) report_fail("dcache_addrOK_timeout");
            @(posedge clk);
            #1;
        end
        dcache_mem_req = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((arb_grant != 2'b00 || data_q.size() != 0) && w < MAXW);
        if (w >= MAXW) report_fail("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [1:0] side);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (arb_grant != side && w < MAXW);
        if (arb_grant != side) report_fail("grant_timeout");
    endtask

    task automatic apply_stimulus();
        // Icache only: addrOK at +2, dataOK at +5
        addr_lat = 2;
        data_lat = 3;
        grant_q.push_back('{2'b01, 1'b0});
        icache_req(1, 32'h1C00_0040, 1'b0);
        wait_idle();

        // A stray dataOK while idle must not reach either cache
        stray_pulse = 1;
        @(negedge clk);
        check_output("stray_seen", mem_arb_dataOK, 1'b1);
        check_output("stray_fwd", {mem_dcache_dataOK, mem_icache_dataOK}, 2'b00);
        wait_idle();

`ifndef ARB_RR_EN
        // Simultaneous requests: Dcache first, Icache one bubble after its dataOK
        addr_lat = 1;
        data_lat = 2;
        grant_q.push_back('{2'b10, 1'b0});
        grant_q.push_back('{2'b01, 1'b1});
        fork
            icache_req(1, 32'h1C00_0100, 1'b0);
            dcache_req(1, 32'h8000_0200, 1'b0, 1'b0, 2'd2, 4'd0, 32'd0);
        join
        wait_idle();

        // Ten back-to-back Dcache reads with the Icache waiting: the ninth grant is the Icache
        addr_lat = 1;
        data_lat = 1;
        grant_q.push_back('{2'b10, 1'b0});
        for (int i = 0; i < 7; i++) grant_q.push_back('{2'b10, 1'b1});
        grant_q.push_back('{2'b01, 1'b1});
        grant_q.push_back('{2'b10, 1'b1});
        grant_q.push_back('{2'b10, 1'b1});
        fork
            icache_req(1, 32'h1C00_0200, 1'b0);
            dcache_req(10, 32'h8000_1000, 1'b0, 1'b0, 2'd2, 4'd0, 32'd0);
        join
        wait_idle();
`else
        // Round-robin with both streaming: D, I, D, I, D, I
        addr_lat = 1;
        data_lat = 1;
        grant_q.push_back('{2'b10, 1'b0});
        grant_q.push_back('{2'b01, 1'b1});
        grant_q.push_back('{2'b10, 1'b1});
        grant_q.push_back('{2'b01, 1'b1});
        grant_q.push_back('{2'b10, 1'b1});
        grant_q.push_back('{2'b01, 1'b1});
        fork
            icache_req(3, 32'h1C00_0300, 1'b0);
            dcache_req(3, 32'h8000_2000, 1'b0, 1'b0, 2'd2, 4'd0, 32'd0);
        join
        wait_idle();
`endif

        // Uncached byte write with addrOK and dataOK together
        addr_lat = 1;
        data_lat = 0;
        grant_q.push_back('{2'b10, 1'b0});
        dcache_req(1, 32'hBFAF_8001, 1'b1, 1'b1, 2'd0, 4'b0010, 32'h0000_AB00);
        wait_idle();

        // Dcache flushes its request before addrOK
        addr_lat = 20;
        grant_q.push_back('{2'b10, 1'b0});
        @(posedge clk);
        #1;
        dcache_mem_req  = 1'b1;
        dcache_mem_wr   = 1'b0;
        addr_dcache_mem = 32'h8000_3000;
        wait_grant(2'b10);
        @(posedge clk);
        #1;
        dcache_mem_req = 1'b0;
        @(negedge clk);
        check_output("abort_hold", {arb_mem_req, mem_dcache_addrOK, mem_dcache_dataOK}, 3'b100);
        @(negedge clk);
        check_output("abort_req", {arb_mem_req, arb_grant}, 3'b000);
        wait_idle();

        // Reset in the middle of an Icache transaction
        grant_q.push_back('{2'b01, 1'b0});
        @(posedge clk);
        #1;
        icache_mem_req  = 1'b1;
        addr_icache_mem = 32'h1C00_0400;
        wait_grant(2'b01);
        #1;
        rstn = 1'b0;
        #1;
        check_output("midreset_out", {arb_mem_req, arb_grant, mem_icache_addrOK, mem_icache_dataOK}, 5'b0);
        check_output("midreset_addr", arb_mem_addr, 32'd0);
        icache_mem_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400000;
        report_fail("watchdog");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn             = 1'b0;
        icache_mem_req   = 1'b0;
        icache_mem_SUC   = 1'b0;
        addr_icache_mem  = 32'd0;
        dcache_mem_req   = 1'b0;
        dcache_mem_wr    = 1'b0;
        dcache_mem_SUC   = 1'b0;
        dcache_mem_size  = 2'd0;
        dcache_mem_wstrb = 4'd0;
        addr_dcache_mem  = 32'd0;
        dout_dcache_mem  = 32'd0;
        arb_rdata        = RDATA;
        repeat (3) @(negedge clk);
        check_output("reset_req_grant", {arb_mem_req, arb_grant}, 3'b000);
        check_output("reset_handshakes",
                     {mem_icache_addrOK, mem_icache_dataOK, mem_dcache_addrOK, mem_dcache_dataOK}, 4'b0);
        check_output("reset_fields", {arb_mem_wr, arb_mem_SUC, arb_mem_size, arb_mem_wstrb, arb_mem_addr},
                     40'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        apply_stimulus();

        check_output("queues_drained", grant_q.size() + exp_i_q.size() + exp_d_q.size() + data_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
